// File: rtl/letc_core_pkg.sv
// ============================================================================
// Module      : letc_core_pkg
// Description : Shared LETC Core types: addresses, words, access sizes and
//               the memory-arbiter state, owner and latched-request types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package letc_core_pkg;

    typedef logic [31:0] paddr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } mem_arb_owner_e;

    typedef struct packed {
        paddr_t addr;
        logic   we;
        size_e  size;
        word_t  wdata;
    } mem_req_s;

endpackage : letc_core_pkg

`default_nettype wire

// File: rtl/letc_core_mem_arb_grant.sv
// ============================================================================
// Module      : letc_core_mem_arb_grant
// Description : Fetch/data grant decision for the memory arbiter. Data wins;
//               with LETC_CORE_MEM_ARB_STARVE_EN a saturating counter forces a
//               fetch grant after STARVE_LIMIT data grants that held fetch off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module letc_core_mem_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic f_valid_i,
    input  logic d_valid_i,
    output logic f_grant_o,
    output logic d_grant_o
);

`ifdef LETC_CORE_MEM_ARB_STARVE_EN
    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             force_fetch;

    assign force_fetch = f_valid_i && (starve_cnt_q == STARVE_MAX);
    assign d_grant_o   = idle_i && d_valid_i && !force_fetch;
    assign f_grant_o   = idle_i && f_valid_i && !d_grant_o;

    // Only a data grant that actually blocked a waiting fetch counts as starving it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (f_grant_o) begin
            starve_cnt_d = '0;
        end else if (d_grant_o) begin
            if (!f_valid_i) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{clk, rst, (STARVE_LIMIT > 0)};
    assign d_grant_o  = idle_i && d_valid_i;
    assign f_grant_o  = idle_i && f_valid_i && !d_valid_i;
`endif

endmodule : letc_core_mem_arb_grant

`default_nettype wire

// File: rtl/letc_core_mem_arb.sv
// ============================================================================
// Module      : letc_core_mem_arb
// Description : Shares the core memory bus between fetch and data requesters;
//               one outstanding access, response routed to its owner.
//               Optional starvation guard: LETC_CORE_MEM_ARB_STARVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module letc_core_mem_arb
    import letc_core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,

    input  logic   f_req_valid,
    output logic   f_req_ready,
    input  paddr_t f_req_addr,
    output logic   f_rsp_valid,
    output word_t  f_rsp_rdata,

    input  logic   d_req_valid,
    output logic   d_req_ready,
    input  paddr_t d_req_addr,
    input  logic   d_req_we,
    input  size_e  d_req_size,
    input  word_t  d_req_wdata,
    output logic   d_rsp_valid,
    output word_t  d_rsp_rdata,

    output logic   bus_req_valid,
    input  logic   bus_req_ready,
    output paddr_t bus_req_addr,
    output logic   bus_req_we,
    output size_e  bus_req_size,
    output word_t  bus_req_wdata,
    input  logic   bus_rsp_valid,
    input  word_t  bus_rsp_rdata
);

    mem_arb_state_e state_q,       state_d;
    mem_arb_owner_e owner_q,       owner_d;
    mem_req_s       req_q,         req_d;
    logic           bus_valid_q,   bus_valid_d;
    logic           f_rsp_valid_q, f_rsp_valid_d;
    logic           d_rsp_valid_q, d_rsp_valid_d;
    word_t          f_rdata_q,     f_rdata_d;
    word_t          d_rdata_q,     d_rdata_d;

    logic           idle;
    logic           f_grant;
    logic           d_grant;

    // Readies must read 0 while reset is held, even if a requester is valid.
    assign idle = (state_q == IDLE) && !rst;

    letc_core_mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .idle_i    (idle),
        .f_valid_i (f_req_valid),
        .d_valid_i (d_req_valid),
        .f_grant_o (f_grant),
        .d_grant_o (d_grant)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        req_d         = req_q;
        bus_valid_d   = bus_valid_q;
        f_rsp_valid_d = 1'b0;
        d_rsp_valid_d = 1'b0;
        f_rdata_d     = f_rdata_q;
        d_rdata_d     = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_grant) begin
                    req_d.addr  = d_req_addr;
                    req_d.we    = d_req_we;
                    req_d.size  = d_req_size;
                    req_d.wdata = d_req_wdata;
                    owner_d     = DATA;
                    bus_valid_d = 1'b1;
                    state_d     = ISSUE;
                end else if (f_grant) begin
                    req_d.addr  = f_req_addr;
                    req_d.we    = 1'b0;
                    req_d.size  = SIZE_WORD;
                    req_d.wdata = '0;
                    owner_d     = FETCH;
                    bus_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus_req_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus_rsp_valid) begin
                    state_d = IDLE;
                    if (owner_q == FETCH) begin
                        f_rsp_valid_d = 1'b1;
                        f_rdata_d     = bus_rsp_rdata;
                    end else begin
                        d_rsp_valid_d = 1'b1;
                        d_rdata_d     = req_q.we ? '0 : bus_rsp_rdata;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= FETCH;
            req_q         <= '0;
            bus_valid_q   <= 1'b0;
            f_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            f_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            req_q         <= req_d;
            bus_valid_q   <= bus_valid_d;
            f_rsp_valid_q <= f_rsp_valid_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            f_rdata_q     <= f_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign f_req_ready   = f_grant;
    assign d_req_ready   = d_grant;
    assign f_rsp_valid   = f_rsp_valid_q;
    assign f_rsp_rdata   = f_rdata_q;
    assign d_rsp_valid   = d_rsp_valid_q;
    assign d_rsp_rdata   = d_rdata_q;
    assign bus_req_valid = bus_valid_q;
    assign bus_req_addr  = req_q.addr;
    assign bus_req_we    = req_q.we;
    assign bus_req_size  = req_q.size;
    assign bus_req_wdata = req_q.wdata;

endmodule : letc_core_mem_arb

`default_nettype wire
